ntt_delay_line: RTL and testbench
=================================

// Module: ntt_delay_line
// PURPOSE
//  Parametrised multi-lane delay line with per-stage valid tracking, stall, flush and
//  run-time selectable depth. Aligns butterfly operands/twiddles with the modular
//  multiplier pipeline in the NTT datapath. Depth can be retuned per mode (NTT/INTT/
//  pointwise) without resynthesis, and occupancy is reported to the NTT controller.
// PARAMETERS
//  WIDTH      24  bits per coefficient lane
//  LANES      4   coefficient lanes carried side by side (bus = LANES*WIDTH)
//  MAX_DEPTH  8   physical stages built; legal run-time depth 1..MAX_DEPTH
//  DEF_DEPTH  5   active depth after reset (1..MAX_DEPTH)
//  DW = $clog2(MAX_DEPTH+1)  derived, width of depth/occupancy fields
// PORTS
//  clk        in   1            rising-edge clock
//  rst_n      in   1            asynchronous active-low reset
//  en         in   1            advance pipeline; 0 = hold all state
//  flush      in   1            sync clear of all valid bits
//  cfg_ld     in   1            request load of cfg_depth
//  cfg_depth  in   DW           requested depth; clamped to 1..MAX_DEPTH
//  in_valid   in   1            in_data carries a sample
//  in_data    in   LANES*WIDTH  lane i at [i*WIDTH +: WIDTH]
//  out_valid  out  1            valid bit of active tap
//  out_data   out  LANES*WIDTH  data of active tap
//  depth      out  DW           active depth (depth_q)
//  occupancy  out  DW           valid samples in stages 0..depth_q-1
//  cfg_err    out  1            1-cycle pulse: cfg_ld rejected
// BEHAVIOUR
//  - Reset: all stage data/valid = 0, depth_q = DEF_DEPTH, occupancy = 0, cfg_err = 0;
//    hence out_valid = 0, out_data = 0, depth = DEF_DEPTH.
//  - Stages s[0..MAX_DEPTH-1], each {v, data}. en=1 & flush=0: s[0] <= {in_valid,in_data},
//    s[k+1] <= s[k]. Data shifts regardless of valid; bubbles propagate as v=0.
//  - Output tap is combinational from register: out_* = s[depth_q-1]. Latency: sample
//    presented with en=1 in cycle t is on out_* in cycle t+depth_q (en=1 every cycle).
//  - en=0: all stages, occupancy, depth_q hold; out_* stable; in_valid ignored.
//  - flush=1 (ignores en): all v <= 0, data untouched, occupancy <= 0; in_valid that
//    cycle dropped.
//  - occupancy (registered): en&~flush: +1 if in_valid, -1 if out_valid, unchanged if both.
//    Never exceeds depth_q.
//  - cfg_ld accepted iff (occupancy==0 | flush). Accept: depth_q <= clamp(cfg_depth);
//    v of s[1..MAX_DEPTH-1] cleared; s[0] loaded per normal rules (en, in_valid, flush);
//    occupancy = 1 if a sample entered s[0] that cycle else 0.
//  - Rejected (occupancy!=0 & ~flush): depth_q unchanged, cfg_err=1 next cycle; pipeline
//    behaves as if cfg_ld=0. cfg_ld is independent of en.
//  - Clamp: cfg_depth=0 -> 1; cfg_depth>MAX_DEPTH -> MAX_DEPTH.
//  - Priority per cycle: rst_n > flush > cfg_ld > en.
//  - Reset asserted mid-operation: immediate async clear of all state.
// TESTING
//  1 Reset, en=1, in_valid=1, in_data=t (t=0..9 per cycle) -> out_valid first in cycle 5
//    with data 0, then 1..9 consecutively; occupancy 1,2,3,4,5 then holds 5.
//  2 Stream at DEF_DEPTH, en=0 for 3 cycles mid-stream -> out_data/occupancy frozen,
//    sequence resumes with no loss or duplication.
//  3 occupancy=3, cfg_ld=1, cfg_depth=2 -> cfg_err pulse, depth stays 5, stream intact;
//    then flush+cfg_ld same cycle -> depth=2, occupancy=0, out_valid=0 next cycle.
//  4 Empty, cfg_ld with cfg_depth=0 -> depth=1 (1-cycle latency); cfg_depth=15 -> depth=8,
//    sample A appears 8 cycles after entry.
//  5 Alternating in_valid 1/0 with values 0xA,0xB -> out_valid alternates, occupancy
//    toggles 2/3 at depth 5; flush -> out_valid=0, occupancy=0 next cycle.
//  6 Assert rst_n=0 asynchronously mid-stream -> out_valid, occupancy drop to 0 before
//    next clk edge; depth returns to 5.

Source files
------------

// File: rtl/ntt_delay_line.sv
// Multi-lane delay line for aligning NTT butterfly operands with the modular
// multiplier pipeline. Depth is selectable at run time up to MAX_DEPTH, each
// stage carries its own valid bit, and the number of valid samples inside the
// active window is reported as occupancy.
module ntt_delay_line #(
  parameter  int unsigned WIDTH     = 24,
  parameter  int unsigned LANES     = 4,
  parameter  int unsigned MAX_DEPTH = 8,
  parameter  int unsigned DEF_DEPTH = 5,
  localparam int unsigned DW        = $clog2(MAX_DEPTH + 1),
  localparam int unsigned BW        = LANES * WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          flush,
  input  logic          cfg_ld,
  input  logic [DW-1:0] cfg_depth,
  input  logic          in_valid,
  input  logic [BW-1:0] in_data,
  output logic          out_valid,
  output logic [BW-1:0] out_data,
  output logic [DW-1:0] depth,
  output logic [DW-1:0] occupancy,
  output logic          cfg_err
);

  logic [BW-1:0]        data_q [MAX_DEPTH];
  logic [BW-1:0]        data_d [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] vld_q;
  logic [MAX_DEPTH-1:0] vld_d;
  logic [DW-1:0]        depth_q;
  logic [DW-1:0]        depth_d;
  logic [DW-1:0]        occ_q;
  logic [DW-1:0]        occ_d;
  logic                 err_q;
  logic                 err_d;

  logic                 adv;
  logic                 cfg_ok;
  logic [DW-1:0]        depth_clamped;

  assign depth     = depth_q;
  assign occupancy = occ_q;
  assign cfg_err   = err_q;

  // Output tap: select stage depth_q-1 straight from the stage registers.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
      if (depth_q == DW'(k + 1)) begin
        out_valid = vld_q[k];
        out_data  = data_q[k];
      end
    end
  end

  // Clamp the requested depth into the legal range 1..MAX_DEPTH.
  always_comb begin
    if (cfg_depth == '0) begin
      depth_clamped = DW'(1);
    end else if (cfg_depth > DW'(MAX_DEPTH)) begin
      depth_clamped = DW'(MAX_DEPTH);
    end else begin
      depth_clamped = cfg_depth;
    end
  end

  // Next-state: shift, then let flush and an accepted reconfiguration override
  // the valid bits and occupancy (flush > cfg_ld > en).
  always_comb begin
    data_d  = data_q;
    vld_d   = vld_q;
    depth_d = depth_q;
    occ_d   = occ_q;
    err_d   = 1'b0;

    adv    = en & ~flush;
    cfg_ok = cfg_ld & ((occ_q == '0) | flush);

    if (adv) begin
      data_d[0] = in_data;
      vld_d[0]  = in_valid;
      for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      if (in_valid && !out_valid) begin
        occ_d = occ_q + DW'(1);
      end else if (!in_valid && out_valid) begin
        occ_d = occ_q - DW'(1);
      end
    end

    if (flush) begin
      vld_d = '0;
      occ_d = '0;
    end

    // An accepted depth change invalidates everything behind stage 0, so the
    // window only ever holds what entered s[0] this very cycle.
    if (cfg_ld) begin
      if (cfg_ok) begin
        depth_d = depth_clamped;
        for (int unsigned k = 1; k < MAX_DEPTH; k++) begin
          vld_d[k] = 1'b0;
        end
        occ_d = (adv && in_valid) ? DW'(1) : '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
        data_q[k] <= '0;
      end
      vld_q   <= '0;
      depth_q <= DW'(DEF_DEPTH);
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
      vld_q   <= vld_d;
      depth_q <= depth_d;
      occ_q   <= occ_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_ntt_delay_line.sv
// Bench for ntt_delay_line: a history-queue reference model (newest sample at
// index 0) gives the expected tap, depth, occupancy and cfg_err each cycle.
module tb_ntt_delay_line;

  localparam int unsigned WIDTH     = 24;
  localparam int unsigned LANES     = 4;
  localparam int unsigned MAX_DEPTH = 8;
  localparam int unsigned DEF_DEPTH = 5;
  localparam int unsigned DW        = $clog2(MAX_DEPTH + 1);
  localparam int unsigned BW        = LANES * WIDTH;
  localparam int unsigned SW        = 1 + BW + DW + DW + 1;

  typedef struct packed {
    logic          v;
    logic [BW-1:0] d;
  } stage_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          flush = 1'b0;
  logic          cfg_ld = 1'b0;
  logic [DW-1:0] cfg_depth = '0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic [BW-1:0] out_data;
  logic [DW-1:0] depth;
  logic [DW-1:0] occupancy;
  logic          cfg_err;
  logic [SW-1:0] dut_snap;

  stage_t hist[$];
  int     m_depth;
  logic   m_err;

  int n_checks = 0;
  int n_fail   = 0;

  ntt_delay_line #(
    .WIDTH    (WIDTH),
    .LANES    (LANES),
    .MAX_DEPTH(MAX_DEPTH),
    .DEF_DEPTH(DEF_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .flush    (flush),
    .cfg_ld   (cfg_ld),
    .cfg_depth(cfg_depth),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .depth    (depth),
    .occupancy(occupancy),
    .cfg_err  (cfg_err)
  );

  assign dut_snap = {out_valid, out_data, depth, occupancy, cfg_err};

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < m_depth; i++) if (hist[i].v) n++;
    return n;
  endfunction

  function automatic logic [SW-1:0] m_snap();
    stage_t tap;
    tap = hist[m_depth-1];
    return {tap.v, tap.d, DW'(m_depth), DW'(m_occ()), m_err};
  endfunction

  task automatic m_reset();
    hist.delete();
    for (int i = 0; i < MAX_DEPTH; i++) hist.push_back('0);
    m_depth = DEF_DEPTH;
    m_err   = 1'b0;
  endtask

  function automatic logic [BW-1:0] rnd_data();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[BW-1:0];
  endfunction

  // Drive one cycle of inputs, advance the model, then land 1 ns after the edge.
  task automatic step(input logic e, input logic f, input logic c,
                      input logic [DW-1:0] cd, input logic iv,
                      input logic [BW-1:0] id);
    bit     acc;
    int     cl;
    stage_t s;
    en = e; flush = f; cfg_ld = c; cfg_depth = cd; in_valid = iv; in_data = id;
    acc = c && ((m_occ() == 0) || f);
    if (e && !f) begin
      s.v = iv;
      s.d = id;
      hist.push_front(s);
      void'(hist.pop_back());
    end
    if (f) foreach (hist[i]) hist[i].v = 1'b0;
    m_err = c && !acc;
    if (c && acc) begin
      cl = (cd == 0) ? 1 : ((int'(cd) > MAX_DEPTH) ? MAX_DEPTH : int'(cd));
      m_depth = cl;
      for (int i = 1; i < MAX_DEPTH; i++) hist[i].v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; flush = 1'b0; cfg_ld = 1'b0; cfg_depth = '0; in_valid = 1'b0; in_data = '0;
    rst_n = 1'b0;
    m_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (dut_snap !== m_snap()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", dut_snap, m_snap());
    end
    n_checks++;
    if ({out_valid, out_data, depth, occupancy, cfg_err} !== {1'b0, {BW{1'b0}}, DW'(DEF_DEPTH), {DW{1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_const got v=%b d=%h depth=%0d occ=%0d err=%b exp v=0 d=0 depth=%0d occ=0 err=0",
               out_valid, out_data, depth, occupancy, cfg_err, DEF_DEPTH);
    end
  endtask

  task automatic test_stream();
    logic          exp_v;
    logic [BW-1:0] exp_d;
    int            exp_o;
    do_reset();
    for (int t = 0; t < 10; t++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, BW'(t));
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL stream_model t=%0d got=%h exp=%h", t, dut_snap, m_snap());
      end
      exp_v = (t >= 4);
      exp_d = (t >= 4) ? BW'(t - 4) : '0;
      exp_o = (t < 5) ? t + 1 : 5;
      n_checks++;
      if ({out_valid, out_data, occupancy} !== {exp_v, exp_d, DW'(exp_o)}) begin
        n_fail++;
        $display("FAIL stream_latency t=%0d got v=%b d=%0h occ=%0d exp v=%b d=%0h occ=%0d",
                 t, out_valid, out_data, occupancy, exp_v, exp_d, exp_o);
      end
    end
  endtask

  task automatic test_stall();
    logic [BW-1:0] sent[$];
    logic [BW-1:0] d;
    int            rx = 0;
    logic          e;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      e = !(c >= 8 && c < 11);
      d = rnd_data();
      if (e) sent.push_back(d);
      step(e, 1'b0, 1'b0, '0, 1'b1, d);
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL stall_model c=%0d got=%h exp=%h", c, dut_snap, m_snap());
      end
      if (e && out_valid) begin
        n_checks++;
        if (out_data !== sent[rx]) begin
          n_fail++;
          $display("FAIL stall_order c=%0d got=%h exp=%h", c, out_data, sent[rx]);
        end
        rx++;
      end
    end
    n_checks++;
    if (rx != 13) begin
      n_fail++;
      $display("FAIL stall_count got=%0d exp=13", rx);
    end
  endtask

  task automatic test_cfg_reject();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, rnd_data());
    step(1'b1, 1'b0, 1'b1, DW'(2), 1'b1, rnd_data());
    n_checks++;
    if ({cfg_err, depth} !== {1'b1, DW'(5)}) begin
      n_fail++;
      $display("FAIL cfg_reject got err=%b depth=%0d exp err=1 depth=5", cfg_err, depth);
    end
    n_checks++;
    if (dut_snap !== m_snap()) begin
      n_fail++;
      $display("FAIL cfg_reject_model got=%h exp=%h", dut_snap, m_snap());
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b1, rnd_data());
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL cfg_after_reject i=%0d got=%h exp=%h", i, dut_snap, m_snap());
      end
    end
    step(1'b1, 1'b1, 1'b1, DW'(2), 1'b1, rnd_data());
    n_checks++;
    if ({depth, occupancy, out_valid, cfg_err} !== {DW'(2), DW'(0), 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL cfg_flush_load got depth=%0d occ=%0d v=%b err=%b exp depth=2 occ=0 v=0 err=0",
               depth, occupancy, out_valid, cfg_err);
    end
  endtask

  task automatic test_clamp();
    logic [BW-1:0] a;
    do_reset();
    step(1'b1, 1'b0, 1'b1, DW'(0), 1'b0, '0);
    n_checks++;
    if (depth !== DW'(1)) begin
      n_fail++;
      $display("FAIL clamp_low got=%0d exp=1", depth);
    end
    step(1'b1, 1'b0, 1'b1, DW'(15), 1'b0, '0);
    n_checks++;
    if (depth !== DW'(8)) begin
      n_fail++;
      $display("FAIL clamp_high got=%0d exp=8", depth);
    end
    a = rnd_data();
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, a);
    for (int j = 1; j <= 7; j++) begin
      step(1'b1, 1'b0, 1'b0, '0, 1'b0, rnd_data());
      n_checks++;
      if (out_valid !== (j == 7)) begin
        n_fail++;
        $display("FAIL depth8_latency j=%0d got v=%b exp v=%b", j, out_valid, (j == 7));
      end
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL depth8_model j=%0d got=%h exp=%h", j, dut_snap, m_snap());
      end
    end
    n_checks++;
    if (out_data !== a) begin
      n_fail++;
      $display("FAIL depth8_data got=%h exp=%h", out_data, a);
    end
  endtask

  task automatic test_alternate();
    logic iv;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      iv = (c % 2 == 0);
      step(1'b1, 1'b0, 1'b0, '0, iv, iv ? BW'('hA) : BW'('hB));
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL alt_model c=%0d got=%h exp=%h", c, dut_snap, m_snap());
      end
      if (c >= 5) begin
        n_checks++;
        if (occupancy !== DW'(2) && occupancy !== DW'(3)) begin
          n_fail++;
          $display("FAIL alt_occ c=%0d got=%0d exp=2or3", c, occupancy);
        end
      end
    end
    step(1'b1, 1'b1, 1'b0, '0, 1'b1, BW'('hA));
    n_checks++;
    if ({out_valid, occupancy} !== {1'b0, DW'(0)}) begin
      n_fail++;
      $display("FAIL alt_flush got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 9) == 0, DW'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1, rnd_data());
      n_checks++;
      if (dut_snap !== m_snap()) begin
        n_fail++;
        $display("FAIL random_model c=%0d got=%h exp=%h", c, dut_snap, m_snap());
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(1'b1, 1'b0, 1'b1, DW'(3), 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1, rnd_data());
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, occupancy, depth} !== {1'b0, DW'(0), DW'(DEF_DEPTH)}) begin
      n_fail++;
      $display("FAIL async_reset got v=%b occ=%0d depth=%0d exp v=0 occ=0 depth=%0d",
               out_valid, occupancy, depth, DEF_DEPTH);
    end
    m_reset();
    en = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b1, rnd_data());
    n_checks++;
    if (dut_snap !== m_snap()) begin
      n_fail++;
      $display("FAIL async_reset_resume got=%h exp=%h", dut_snap, m_snap());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_cfg_reject();
    test_clamp();
    test_alternate();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
